puf_challenge_expander: RTL and testbench

Control-and-capture stage wrapped around the 16-bit LFSR challenge generator. It accepts a 16-bit seed, seeds the LFSR and starts it. Each time the LFSR signals a settled word, it captures the word and advances the LFSR, eight times in all. It then presents the concatenated 128-bit challenge downstream to the 128-bit PUF path over a valid/ready handshake.

---
 rtl/puf_challenge_expander_pkg.sv | 16 +
 rtl/puf_challenge_expander_if.sv | 35 +++
 rtl/puf_challenge_expander.sv | 115 +++++++++++
 tb/tb_puf_challenge_expander.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_challenge_expander_pkg.sv
// Shared types and constants for the PUF challenge expander and its bus interface.
package puf_challenge_expander_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    NEXT,
    DONE
  } state_t;

  localparam int LFSR_W        = 16;
  localparam int DEF_NUM_WORDS = 8;
  localparam int DEF_TIMEOUT   = 31;

endpackage

// File: rtl/puf_challenge_expander_if.sv
// Seed handshake, LFSR control/capture and challenge handshake grouped as one bus.
interface puf_challenge_expander_if
  import puf_challenge_expander_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS
);

  logic [LFSR_W-1:0]           seed;
  logic                        seed_valid;
  logic                        seed_ready;
  logic                        lfsr_start_new;
  logic                        lfsr_next;
  logic [LFSR_W-1:0]           lfsr_seed;
  logic [LFSR_W-1:0]           lfsr_r;
  logic                        lfsr_en;
  logic [LFSR_W*NUM_WORDS-1:0] chal;
  logic                        chal_valid;
  logic                        chal_ready;
  logic                        busy;
  logic                        err;

  // The expander side: it consumes seeds and LFSR words, produces challenges.
  modport master (
    input  seed, seed_valid, lfsr_r, lfsr_en, chal_ready,
    output seed_ready, lfsr_start_new, lfsr_next, lfsr_seed,
           chal, chal_valid, busy, err
  );

  modport slave (
    output seed, seed_valid, lfsr_r, lfsr_en, chal_ready,
    input  seed_ready, lfsr_start_new, lfsr_next, lfsr_seed,
           chal, chal_valid, busy, err
  );

endinterface

// File: rtl/puf_challenge_expander.sv
// Seeds and steps an external 16-bit LFSR, captures NUM_WORDS settled words and
// offers the concatenated challenge downstream over valid/ready.
module puf_challenge_expander
  import puf_challenge_expander_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input logic                     clk,
  input logic                     rst,
  puf_challenge_expander_if.master bus
);

  localparam int CW = LFSR_W * NUM_WORDS;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

  state_t            state;
  logic [LFSR_W-1:0] seedQ;
  logic [CW-1:0]     chalQ;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tcnt;
  logic              startNew;
  logic              nextPulse;
  logic              validQ;
  logic              readyQ;
  logic              busyQ;
  logic              errQ;

  // tcnt == 0 marks the guard cycle: the LFSR has not yet reacted to the
  // latest start_new/next, so a still-high lfsr_en would be stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seedQ     <= '0;
      chalQ     <= '0;
      idx       <= '0;
      tcnt      <= '0;
      startNew  <= 1'b0;
      nextPulse <= 1'b0;
      validQ    <= 1'b0;
      readyQ    <= 1'b1;
      busyQ     <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      nextPulse <= 1'b0;
      case (state)
        IDLE: begin
          startNew <= 1'b0;
          if (bus.seed_valid && readyQ) begin
            seedQ  <= bus.seed;
            errQ   <= 1'b0;
            chalQ  <= '0;
            idx    <= '0;
            readyQ <= 1'b0;
            busyQ  <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          startNew <= 1'b1;
          tcnt     <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (tcnt != '0 && bus.lfsr_en) begin
            chalQ[LFSR_W*idx +: LFSR_W] <= bus.lfsr_r;
            if (idx == LAST_IDX) begin
              validQ <= 1'b1;
              state  <= DONE;
            end else begin
              idx       <= idx + 1'b1;
              nextPulse <= 1'b1;
              state     <= NEXT;
            end
          end else if (tcnt == TMAX) begin
            errQ     <= 1'b1;
            startNew <= 1'b0;
            readyQ   <= 1'b1;
            busyQ    <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        NEXT: begin
          tcnt  <= '0;
          state <= RUN;
        end
        DONE: begin
          if (bus.chal_ready) begin
            validQ   <= 1'b0;
            startNew <= 1'b0;
            readyQ   <= 1'b1;
            busyQ    <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.seed_ready     = readyQ;
  assign bus.lfsr_start_new = startNew;
  assign bus.lfsr_next      = nextPulse;
  assign bus.lfsr_seed      = seedQ;
  assign bus.chal           = chalQ;
  assign bus.chal_valid     = validQ;
  assign bus.busy           = busyQ;
  assign bus.err            = errQ;

endmodule

// File: tb/tb_puf_challenge_expander.sv
// Scoreboard bench: a behavioural LFSR stand-in drives the expander, and a monitor
// compares each delivered challenge with the value computed from the seed.
module tb_puf_challenge_expander;
  import puf_challenge_expander_pkg::*;

  localparam int NW      = DEF_NUM_WORDS;
  localparam int TO      = DEF_TIMEOUT;
  localparam int CW      = 16 * NW;
  localparam int LAT_MAX = 8 * 16;
  localparam int BUDGET  = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puf_challenge_expander_if #(.NUM_WORDS(NW)) bus();

  puf_challenge_expander #(.NUM_WORDS(NW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [CW-1:0] expq[$];

  // x^16 + x^14 + x^13 + x^11 Fibonacci step; the all-zero state is a fixed point.
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [CW-1:0] expectedChal(input logic [15:0] s);
    logic [CW-1:0] c;
    logic [15:0]   w;
    c = '0;
    w = s;
    for (int k = 0; k < NW; k++) begin
      w = lfsrStep(w);
      c[16*k +: 16] = w;
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // LFSR stand-in: loads while start_new is low, then settles after a random delay.
  logic [15:0] lreg;
  logic        len;
  int          lcnt;
  logic        mute = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lreg <= '0;
      len  <= 1'b0;
      lcnt <= 0;
    end else if (!bus.lfsr_start_new) begin
      lreg <= bus.lfsr_seed;
      len  <= 1'b0;
      lcnt <= int'($urandom_range(11, 6));
    end else if (bus.lfsr_next) begin
      len  <= 1'b0;
      lcnt <= int'($urandom_range(11, 6));
    end else if (!len) begin
      if (lcnt == 0) begin
        lreg <= lfsrStep(lreg);
        len  <= 1'b1;
      end else begin
        lcnt <= lcnt - 1;
      end
    end
  end

  assign bus.lfsr_r  = lreg;
  assign bus.lfsr_en = len & ~mute;

  // Monitor: protocol rules every cycle, scoreboard pop on each completed transfer.
  int   cyc = 0;
  int   pulses = 0;
  int   hsCyc = 0;
  logic prevValid = 1'b0;
  logic prevNext = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pulses    = 0;
      prevValid = 1'b0;
      prevNext  = 1'b0;
    end else begin
      if (bus.seed_valid && bus.seed_ready) begin
        pulses = 0;
        hsCyc  = cyc;
      end
      if (bus.lfsr_next) begin
        checkOutput("next_back_to_back", prevNext, 1'b0);
        checkOutput("next_while_loading", bus.lfsr_start_new, 1'b1);
        pulses++;
      end
      if (bus.chal_valid && !prevValid)
        checkOutput("latency_in_bound", (cyc - hsCyc) <= LAT_MAX, 1'b1);
      if (bus.chal_valid && bus.chal_ready) begin
        if (expq.size() == 0) checkOutput("unexpected_chal", bus.chal_valid, 1'b0);
        else checkOutput("chal_data", bus.chal, expq.pop_front());
        checkOutput("next_pulse_count", pulses, NW - 1);
        checkOutput("err_at_done", bus.err, 1'b0);
      end
      prevValid = bus.chal_valid;
      prevNext  = bus.lfsr_next;
    end
  end

  task automatic applyStimulus(input logic [15:0] s, input bit expectChal);
    int n;
    n = 0;
    while (!bus.seed_ready && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("seed_ready_wait", bus.seed_ready, 1'b1);
    bus.seed       = s;
    bus.seed_valid = 1'b1;
    @(posedge clk); #1;
    bus.seed_valid = 1'b0;
    bus.seed       = 16'($urandom());
    if (expectChal) expq.push_back(expectedChal(s));
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, bus.busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [CW-1:0] snap;
    logic [15:0]   sA;
    int            n;

    rst            = 1'b1;
    bus.seed       = '0;
    bus.seed_valid = 1'b0;
    bus.chal_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_seed_ready", bus.seed_ready, 1'b1);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_chal_valid", bus.chal_valid, 1'b0);
    checkOutput("rst_err", bus.err, 1'b0);
    checkOutput("rst_start_new", bus.lfsr_start_new, 1'b0);
    checkOutput("rst_next", bus.lfsr_next, 1'b0);
    checkOutput("rst_chal", bus.chal, '0);
    checkOutput("rst_lfsr_seed", bus.lfsr_seed, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] zero seed and ACE1 seed");
    applyStimulus(16'h0000, 1'b1);
    waitIdle("idle_after_zero");
    checkOutput("err_zero_seed", bus.err, 1'b0);
    applyStimulus(16'hACE1, 1'b1);
    checkOutput("lfsr_seed_ace1", bus.lfsr_seed, 16'hACE1);
    waitIdle("idle_after_ace1");

    $display("[TB] backpressure in DONE");
    bus.chal_ready = 1'b0;
    applyStimulus(16'h5A3C, 1'b1);
    n = 0;
    while (!bus.chal_valid && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("valid_rise", bus.chal_valid, 1'b1);
    snap = bus.chal;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", bus.chal_valid, 1'b1);
      checkOutput("hold_chal", bus.chal, snap);
      checkOutput("hold_seed_ready", bus.seed_ready, 1'b0);
    end
    bus.chal_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_valid", bus.chal_valid, 1'b0);
    checkOutput("release_seed_ready", bus.seed_ready, 1'b1);
    checkOutput("release_busy", bus.busy, 1'b0);
    checkOutput("release_start_new", bus.lfsr_start_new, 1'b0);

    $display("[TB] timeout with lfsr_en stuck low");
    mute = 1'b1;
    applyStimulus(16'hBEEF, 1'b0);
    n = 0;
    while (bus.busy && n < BUDGET) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("timeout_busy_cycles", n, TO + 2);
    checkOutput("timeout_err", bus.err, 1'b1);
    checkOutput("timeout_valid", bus.chal_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_sticky", bus.err, 1'b1);
    mute = 1'b0;
    applyStimulus(16'h0F0F, 1'b1);
    checkOutput("err_cleared_on_seed", bus.err, 1'b0);
    waitIdle("idle_after_timeout_recovery");

    $display("[TB] reset during word 3");
    applyStimulus(16'h7331, 1'b1);
    n = 0;
    for (int i = 0; i < BUDGET && n < 2; i++) begin
      @(posedge clk); #1;
      if (bus.lfsr_next) n++;
    end
    checkOutput("reached_word3", n, 2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_start_new", bus.lfsr_start_new, 1'b0);
    checkOutput("midrst_chal", bus.chal, '0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    checkOutput("midrst_valid", bus.chal_valid, 1'b0);
    checkOutput("midrst_seed_ready", bus.seed_ready, 1'b1);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(16'hC0DE, 1'b1);
    waitIdle("idle_after_midrst");

    $display("[TB] seed offered while running");
    sA = 16'($urandom());
    applyStimulus(sA, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.seed       = 16'h1234;
    bus.seed_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("busy_seed_ready", bus.seed_ready, 1'b0);
      checkOutput("busy_lfsr_seed", bus.lfsr_seed, sA);
    end
    bus.seed_valid = 1'b0;
    waitIdle("idle_after_ignored_seed");

    $display("[TB] back-to-back random seeds");
    for (int i = 0; i < 5; i++) applyStimulus(16'($urandom()), 1'b1);
    waitIdle("idle_after_random");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
